alu_operand_sequencer: RTL

//  Front-end controller that initiates every ALU operation: captures operand A, operand B and the
//  op code from board switches on debounced button presses. Drives the 4-bit add/sub/and/xor ALU.

---
 rtl/alu_operand_sequencer_if.sv | 20 ++
 rtl/alu_operand_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer_if.sv
// Operand/result bus between alu_operand_sequencer (master) and the combinational 4-bit ALU (slave).
interface alu_operand_sequencer_if;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_s0;
    logic       alu_s1;
    logic [3:0] alu_r;
    logic       alu_cout;
    logic       alu_ovr;

    modport master (
        output alu_a, alu_b, alu_s0, alu_s1,
        input  alu_r, alu_cout, alu_ovr
    );

    modport slave (
        input  alu_a, alu_b, alu_s0, alu_s1,
        output alu_r, alu_cout, alu_ovr
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Captures A, B and op code from switches on debounced enter presses, then registers the ALU result.
// Optional feature macro: ACCUM_EN (enter in SHOW feeds the result back as operand A).
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    sw,
    input  logic                          btn_enter,
    input  logic                          btn_clr,
    alu_operand_sequencer_if.master       alu,
    output logic [3:0]                    result,
    output logic                          result_cout,
    output logic                          result_ovr,
    output logic                          result_valid,
    output logic [2:0]                    stage
);

    typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW} stateT;

    // Index 0 is enter, index 1 is clear.
    logic [1:0]            rawBtn;
    logic [1:0]            syncMeta;
    logic [1:0]            syncLevel;
    logic [1:0]            accepted;
    logic [1:0]            pressPulse;
    logic [1:0][CNT_W-1:0] debCnt;

    logic enterPulse;
    logic clrPulse;

    assign rawBtn     = {btn_clr, btn_enter};
    assign enterPulse = pressPulse[0];
    assign clrPulse   = pressPulse[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncMeta   <= '0;
            syncLevel  <= '0;
            accepted   <= '0;
            pressPulse <= '0;
            debCnt     <= '0;
        end else begin
            syncMeta   <= rawBtn;
            syncLevel  <= syncMeta;
            pressPulse <= '0;
            for (int i = 0; i < 2; i++) begin
                if (syncLevel[i] == accepted[i]) begin
                    debCnt[i] <= '0;
                end else if (debCnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    accepted[i]   <= ~accepted[i];
                    debCnt[i]     <= '0;
                    pressPulse[i] <= ~accepted[i];  // only the rising acceptance is a press
                end else begin
                    debCnt[i] <= debCnt[i] + CNT_W'(1);
                end
            end
        end
    end

    stateT state;
    stateT nextState;
    logic  loadA;
    logic  loadB;
    logic  loadOp;
    logic  capture;
    logic  clearRegs;
`ifdef ACCUM_EN
    logic  accumLoad;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD_A;
        else        state <= nextState;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        nextState    = state;
        loadA        = 1'b0;
        loadB        = 1'b0;
        loadOp       = 1'b0;
        capture      = 1'b0;
        clearRegs    = 1'b0;
`ifdef ACCUM_EN
        accumLoad    = 1'b0;
`endif
        stage        = 3'b000;
        result_valid = 1'b0;

        case (state)
            LOAD_A:  stage = 3'b001;
            LOAD_B:  stage = 3'b010;
            LOAD_OP: stage = 3'b100;
            SHOW:    result_valid = 1'b1;
            default: ;
        endcase

        // Clear outranks a simultaneous enter; EXEC never waits on enter.
        if (clrPulse) begin
            nextState = LOAD_A;
            clearRegs = 1'b1;
        end else begin
            case (state)
                LOAD_A:  if (enterPulse) begin loadA  = 1'b1; nextState = LOAD_B;  end
                LOAD_B:  if (enterPulse) begin loadB  = 1'b1; nextState = LOAD_OP; end
                LOAD_OP: if (enterPulse) begin loadOp = 1'b1; nextState = EXEC;    end
                EXEC:    begin capture = 1'b1; nextState = SHOW; end
                SHOW: begin
                    if (enterPulse) begin
`ifdef ACCUM_EN
                        accumLoad = 1'b1;
                        nextState = LOAD_B;
`else
                        nextState = LOAD_A;
`endif
                    end
                end
                default: nextState = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu.alu_a   <= '0;
            alu.alu_b   <= '0;
            alu.alu_s0  <= 1'b0;
            alu.alu_s1  <= 1'b0;
            result      <= '0;
            result_cout <= 1'b0;
            result_ovr  <= 1'b0;
        end else if (clearRegs) begin
            alu.alu_a   <= '0;
            alu.alu_b   <= '0;
            alu.alu_s0  <= 1'b0;
            alu.alu_s1  <= 1'b0;
            result      <= '0;
            result_cout <= 1'b0;
            result_ovr  <= 1'b0;
        end else begin
            if (loadA) alu.alu_a <= sw;
`ifdef ACCUM_EN
            if (accumLoad) alu.alu_a <= result;
`endif
            if (loadB) alu.alu_b <= sw;
            if (loadOp) begin
                alu.alu_s1 <= sw[1];
                alu.alu_s0 <= sw[0];
            end
            if (capture) begin
                result      <= alu.alu_r;
                result_cout <= alu.alu_cout;
                result_ovr  <= alu.alu_ovr;
            end
        end
    end

endmodule
